// File: rtl/uart_frame_ram_writer.sv
// UART frame receiver: HEADER | pixels | HEADER byte stream into frame RAM writes.
// Reports frame status, the last written pixel position and the pixel count.
module uart_frame_ram_writer #(
    parameter int         PIX_W     = 12,
    parameter int         IMG_W     = 160,
    parameter int         IMG_H     = 120,
    parameter int         ADDR_W    = 15,
    parameter int         BASE_ADDR = 0,
    parameter logic [7:0] HEADER    = 8'h5A,
    parameter int         TIMEOUT   = 500_000
) (
    input  logic              i_clk_sys,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_clear,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [PIX_W-1:0]  o_ram_din,
    output logic              o_ram_wre,
    output logic              o_receiving,
    output logic              o_complete,
    output logic              o_error,
    output logic [1:0]        o_err_code,
    output logic [ADDR_W-1:0] o_pix_cnt,
    output logic [11:0]       o_xpos,
    output logic [11:0]       o_ypos
);

    localparam int BPP  = (PIX_W <= 8) ? 1 : 2;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RECV, TRAILER, DONE, ERR} state_t;

    state_t          state, state_d;
    logic [7:0]      hold;
    logic            byte_idx;
    logic [TW-1:0]   timer;
    logic [11:0]     col, row;
    logic            start, take, wr, last_byte, pix_last;
    logic            tmo, is_hdr, in_frame;
    logic [1:0]      code_d;
    logic [15:0]     word;
    logic [PIX_W-1:0] pixel;

    assign is_hdr    = i_rx_valid && (i_rx_data == HEADER);
    assign last_byte = (BPP == 1) || byte_idx;
    assign pix_last  = (o_pix_cnt == ADDR_W'(NPIX - 1));
    assign tmo       = !i_rx_valid && (timer == TW'(TIMEOUT - 1));
    assign in_frame  = (state == RECV) || (state == TRAILER);
    assign wr        = take && last_byte;

    // Left-justify the assembled bytes; the shift drops the low pad bits.
    assign word  = (BPP == 2) ? {hold, i_rx_data} : {i_rx_data, 8'h00};
    assign pixel = PIX_W'(word >> (16 - PIX_W));

    always_comb begin
        state_d = state;
        start   = 1'b0;
        take    = 1'b0;
        code_d  = 2'd0;
        if (i_clear) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (is_hdr) begin
                        state_d = RECV;
                        start   = 1'b1;
                    end
                end
                RECV: begin
                    if (i_rx_valid) begin
                        take = 1'b1;
                        if (last_byte && pix_last)
                            state_d = TRAILER;
                    end else if (tmo) begin
                        state_d = ERR;
                        code_d  = 2'd2;
                    end
                end
                TRAILER: begin
                    if (i_rx_valid) begin
                        state_d = is_hdr ? DONE : ERR;
                        code_d  = is_hdr ? 2'd0 : 2'd1;
                    end else if (tmo) begin
                        state_d = ERR;
                        code_d  = 2'd2;
                    end
                end
                ERR: state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            hold        <= '0;
            byte_idx    <= 1'b0;
            timer       <= '0;
            col         <= '0;
            row         <= '0;
            o_ram_addr  <= '0;
            o_ram_din   <= '0;
            o_ram_wre   <= 1'b0;
            o_receiving <= 1'b0;
            o_complete  <= 1'b0;
            o_error     <= 1'b0;
            o_err_code  <= 2'd0;
            o_pix_cnt   <= '0;
            o_xpos      <= '0;
            o_ypos      <= '0;
        end else begin
            state       <= state_d;
            o_receiving <= (state_d == RECV) || (state_d == TRAILER);
            o_ram_wre   <= wr;

            if (start) begin
                timer     <= '0;
                byte_idx  <= 1'b0;
                col       <= '0;
                row       <= '0;
                o_pix_cnt <= '0;
                o_xpos    <= '0;
                o_ypos    <= '0;
            end else if (in_frame) begin
                timer <= i_rx_valid ? '0 : timer + 1'b1;
            end

            if (take) begin
                byte_idx <= !last_byte;
                if (!last_byte)
                    hold <= i_rx_data;
            end

            if (wr) begin
                o_ram_addr <= ADDR_W'(BASE_ADDR) + o_pix_cnt;
                o_ram_din  <= pixel;
                o_pix_cnt  <= o_pix_cnt + 1'b1;
                o_xpos     <= col;
                o_ypos     <= row;
                if (col == 12'(IMG_W - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            if (i_clear) begin
                o_complete <= 1'b0;
                o_error    <= 1'b0;
                o_err_code <= 2'd0;
            end else if (start) begin
                o_complete <= 1'b0;
            end else if (state == TRAILER && state_d == DONE) begin
                o_complete <= 1'b1;
            end else if (state_d == ERR && state != ERR) begin
                o_error    <= 1'b1;
                o_err_code <= code_d;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_ram_writer.sv
// Scoreboard bench: stimulus pushes expected RAM writes, a monitor pops them.
// Two instances cover the 12-bit and the 8-bit/offset-base configurations.
module tb_uart_frame_ram_writer;

    localparam int TMO = 40;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] din;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, a_valid, a_clear;
    logic [7:0]  a_data;
    logic [14:0] a_addr, a_cnt;
    logic [11:0] a_din, a_x, a_y;
    logic        a_wre, a_recv, a_cmp, a_err;
    logic [1:0]  a_code;

    logic        b_rst_n, b_valid, b_clear;
    logic [7:0]  b_data;
    logic [14:0] b_addr, b_cnt;
    logic [7:0]  b_din;
    logic [11:0] b_x, b_y;
    logic        b_wre, b_recv, b_cmp, b_err;
    logic [1:0]  b_code;

    uart_frame_ram_writer #(
        .PIX_W(12), .IMG_W(5), .IMG_H(4), .ADDR_W(15),
        .BASE_ADDR(0), .HEADER(8'h5A), .TIMEOUT(TMO)
    ) dut_a (
        .i_clk_sys(clk), .i_rst_n(a_rst_n), .i_rx_data(a_data),
        .i_rx_valid(a_valid), .i_clear(a_clear),
        .o_ram_addr(a_addr), .o_ram_din(a_din), .o_ram_wre(a_wre),
        .o_receiving(a_recv), .o_complete(a_cmp), .o_error(a_err),
        .o_err_code(a_code), .o_pix_cnt(a_cnt), .o_xpos(a_x), .o_ypos(a_y)
    );

    uart_frame_ram_writer #(
        .PIX_W(8), .IMG_W(5), .IMG_H(4), .ADDR_W(15),
        .BASE_ADDR(100), .HEADER(8'h5A), .TIMEOUT(TMO)
    ) dut_b (
        .i_clk_sys(clk), .i_rst_n(b_rst_n), .i_rx_data(b_data),
        .i_rx_valid(b_valid), .i_clear(b_clear),
        .o_ram_addr(b_addr), .o_ram_din(b_din), .o_ram_wre(b_wre),
        .o_receiving(b_recv), .o_complete(b_cmp), .o_error(b_err),
        .o_err_code(b_code), .o_pix_cnt(b_cnt), .o_xpos(b_x), .o_ypos(b_y)
    );

    wr_t q_a[$];
    wr_t q_b[$];
    int  checks = 0;
    int  errors = 0;
    int  wcnt_a = 0;

    always @(negedge clk) begin
        wr_t e;
        if (a_wre) begin
            wcnt_a++;
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL a_write unexpected: addr=%0d din=%h", a_addr, a_din);
            end else begin
                e = q_a.pop_front();
                if (a_addr !== e.addr || {4'h0, a_din} !== e.din) begin
                    errors++;
                    $display("FAIL a_write: got addr=%0d din=%h, want addr=%0d din=%h",
                             a_addr, a_din, e.addr, e.din);
                end
            end
        end
        if (b_wre) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL b_write unexpected: addr=%0d din=%h", b_addr, b_din);
            end else begin
                e = q_b.pop_front();
                if (b_addr !== e.addr || {8'h00, b_din} !== e.din) begin
                    errors++;
                    $display("FAIL b_write: got addr=%0d din=%h, want addr=%0d din=%h",
                             b_addr, b_din, e.addr, e.din);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] b);
        a_data  = b;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        b_data  = b;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    task automatic pulse_clear_a();
        a_clear = 1'b1;
        @(negedge clk);
        a_clear = 1'b0;
    endtask

    // Pixel 5 is 0x5A,0x50 so a HEADER byte shows up inside the data.
    function automatic logic [15:0] pix_bytes(input int i);
        if (i == 5)
            return 16'h5A50;
        return {8'(i * 37 + 11), 8'(i * 91 + 3)};
    endfunction

    task automatic frame_a(input int npix, input bit trl_en,
                           input logic [7:0] trl, input bit half);
        logic [15:0] pb;
        send_a(8'h5A);
        for (int i = 0; i < npix; i++) begin
            pb = pix_bytes(i);
            q_a.push_back('{addr: 15'(i), din: {4'h0, pb[15:4]}});
            send_a(pb[15:8]);
            send_a(pb[7:0]);
        end
        if (half) begin
            pb = pix_bytes(npix);
            send_a(pb[15:8]);
        end
        if (trl_en)
            send_a(trl);
    endtask

    task automatic status_a(input string tag, input int recv, input int cmp,
                            input int err, input int code);
        chk({tag, "_receiving"}, a_recv, recv);
        chk({tag, "_complete"}, a_cmp, cmp);
        chk({tag, "_error"}, a_err, err);
        chk({tag, "_err_code"}, a_code, code);
    endtask

    initial begin
        logic [7:0] bb;
        a_rst_n = 1'b0; a_valid = 1'b0; a_clear = 1'b0; a_data = 8'h00;
        b_rst_n = 1'b0; b_valid = 1'b0; b_clear = 1'b0; b_data = 8'h00;
        cycles(3);

        status_a("reset", 0, 0, 0, 0);
        chk("reset_wre", a_wre, 0);
        chk("reset_pix_cnt", a_cnt, 0);
        chk("reset_addr", a_addr, 0);
        chk("reset_xy", {a_x, a_y}, 0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        cycles(2);

        // Non-header bytes in IDLE produce nothing.
        send_a(8'h11);
        send_a(8'h22);
        cycles(2);
        chk("idle_receiving", a_recv, 0);
        chk("idle_writes", wcnt_a, 0);

        frame_a(10, 1'b0, 8'h00, 1'b0);
        chk("mid_receiving", a_recv, 1);
        chk("mid_pix_cnt", a_cnt, 10);
        frame_a(0, 1'b0, 8'h00, 1'b0);
        q_a.delete();
        wcnt_a = 0;
        pulse_clear_a();
        cycles(1);

        // Good frame.
        frame_a(20, 1'b1, 8'h5A, 1'b0);
        cycles(3);
        status_a("good", 0, 1, 0, 0);
        chk("good_pix_cnt", a_cnt, 20);
        chk("good_xpos", a_x, 4);
        chk("good_ypos", a_y, 3);
        chk("good_writes", wcnt_a, 20);
        chk("good_queue", q_a.size(), 0);

        // Bad trailer, started from DONE.
        frame_a(20, 1'b1, 8'h33, 1'b0);
        cycles(3);
        status_a("badtrl", 0, 0, 1, 1);
        pulse_clear_a();
        cycles(1);
        status_a("clear", 0, 0, 0, 0);
        chk("clear_keeps_cnt", a_cnt, 20);

        // Clear mid-frame aborts without an error flag.
        frame_a(3, 1'b0, 8'h00, 1'b0);
        chk("abort_receiving_pre", a_recv, 1);
        pulse_clear_a();
        cycles(1);
        status_a("abort", 0, 0, 0, 0);
        chk("abort_cnt", a_cnt, 3);

        // Byte timeout after 7.5 pixels.
        wcnt_a = 0;
        frame_a(7, 1'b0, 8'h00, 1'b1);
        cycles(TMO - 1);
        chk("tmo_edge_receiving", a_recv, 1);
        chk("tmo_edge_error", a_err, 0);
        cycles(1);
        status_a("tmo", 0, 0, 1, 2);
        cycles(3);
        chk("tmo_writes", wcnt_a, 7);
        chk("tmo_pix_cnt", a_cnt, 7);
        send_a(8'h5A);
        cycles(1);
        chk("err_ignores_header", a_recv, 0);
        pulse_clear_a();
        cycles(1);

        // Reset mid-frame, then a complete frame.
        frame_a(10, 1'b0, 8'h00, 1'b0);
        cycles(2);
        a_rst_n = 1'b0;
        cycles(1);
        a_rst_n = 1'b1;
        chk("rst_mid_queue", q_a.size(), 0);
        status_a("rst_mid", 0, 0, 0, 0);
        chk("rst_mid_cnt", a_cnt, 0);
        wcnt_a = 0;
        frame_a(20, 1'b1, 8'h5A, 1'b0);
        cycles(3);
        status_a("rst_new", 0, 1, 0, 0);
        chk("rst_new_writes", wcnt_a, 20);

        // 8-bit pixels at BASE_ADDR 100.
        send_b(8'h5A);
        for (int i = 0; i < 20; i++) begin
            bb = (i == 9) ? 8'h5A : 8'(i * 13 + 7);
            q_b.push_back('{addr: 15'(100 + i), din: {8'h00, bb}});
            send_b(bb);
        end
        send_b(8'h5A);
        cycles(3);
        chk("b_complete", b_cmp, 1);
        chk("b_error", b_err, 0);
        chk("b_pix_cnt", b_cnt, 20);
        chk("b_xy", {b_x, b_y}, {12'd4, 12'd3});
        chk("b_queue", q_b.size(), 0);
        chk("a_queue_end", q_a.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
